// File: rtl/edc_pkg.sv
// Shared constants, types and helpers for the (40,32) SECDED engine.
package edc_pkg;

    localparam int DATA_W  = 32;
    localparam int CHECK_W = 8;

    // Parity check matrix rows, row 7 first; MSB of each row is data bit 31.
    localparam logic [DATA_W-1:0] H_ROW7 = 32'hAAAAC0C0;
    localparam logic [DATA_W-1:0] H_ROW6 = 32'h55553030;
    localparam logic [DATA_W-1:0] H_ROW5 = 32'hFF000C0C;
    localparam logic [DATA_W-1:0] H_ROW4 = 32'h00FF0303;
    localparam logic [DATA_W-1:0] H_ROW3 = 32'hC0C0FF00;
    localparam logic [DATA_W-1:0] H_ROW2 = 32'h303000FF;
    localparam logic [DATA_W-1:0] H_ROW1 = 32'h0C0CAAAA;
    localparam logic [DATA_W-1:0] H_ROW0 = 32'h03035555;

    localparam logic [CHECK_W-1:0][DATA_W-1:0] H_ROWS =
        {H_ROW7, H_ROW6, H_ROW5, H_ROW4, H_ROW3, H_ROW2, H_ROW1, H_ROW0};

    typedef enum logic [1:0] {
        NONE      = 2'd0,
        SEC_DATA  = 2'd1,
        SEC_CHECK = 2'd2,
        DED       = 2'd3
    } dec_result_e;

    // Syndrome pattern produced by a flip of data bit j (always weight 3).
    function automatic logic [CHECK_W-1:0] h_column(input logic [4:0] j);
        logic [CHECK_W-1:0] col;
        for (int r = 0; r < CHECK_W; r++) begin
            col[r] = H_ROWS[r][j];
        end
        return col;
    endfunction

    // Check byte of one 32-bit lane: per-row parity of the masked data.
    function automatic logic [CHECK_W-1:0] gen_check(input logic [DATA_W-1:0] data);
        logic [CHECK_W-1:0] chk;
        for (int r = 0; r < CHECK_W; r++) begin
            chk[r] = ^(H_ROWS[r] & data);
        end
        return chk;
    endfunction

    // Number of set bits in a syndrome byte.
    function automatic logic [3:0] check_weight(input logic [CHECK_W-1:0] v);
        logic [3:0] w;
        w = 4'd0;
        for (int i = 0; i < CHECK_W; i++) begin
            w = w + {3'd0, v[i]};
        end
        return w;
    endfunction

endpackage

// File: rtl/edc_secded_pipe_lane.sv
// One 32-bit lane: syndrome generation (front half) and decode/correct (back half).
// The halves are separate so the top can place a register between them.
module edc_lane_decode
    import edc_pkg::*;
(
    input  logic [DATA_W-1:0]  syn_data,
    input  logic [CHECK_W-1:0] syn_ecc,
    input  logic               syn_write,
    output logic [CHECK_W-1:0] syndrome,
    input  logic [DATA_W-1:0]  cor_data,
    input  logic [CHECK_W-1:0] cor_syndrome,
    output logic [DATA_W-1:0]  fixed_data,
    output logic [CHECK_W-1:0] fixed_ecc,
    output logic               sec,
    output logic               ded
);

    dec_result_e        result_s;
    logic [DATA_W-1:0]  flip_s;
    logic [3:0]         weight_s;

    // Write beats carry a zero syndrome so the decode half passes them untouched.
    always_comb begin
        syndrome = 8'd0;
        if (syn_write) begin
            syndrome = 8'd0;
        end else begin
            syndrome = gen_check(syn_data) ^ syn_ecc;
        end
    end

    // Mark the data bit whose column equals the syndrome (at most one, columns are unique).
    always_comb begin
        flip_s = 32'd0;
        for (int j = 0; j < DATA_W; j++) begin
            flip_s[j] = (cor_syndrome == h_column(5'(j)));
        end
    end

    // Classify the syndrome.
    always_comb begin
        result_s = NONE;
        weight_s = check_weight(cor_syndrome);
        if (cor_syndrome == 8'd0) begin
            result_s = NONE;
        end else if (weight_s == 4'd1) begin
            result_s = SEC_CHECK;
        end else if (!weight_s[0]) begin
            result_s = DED;
        end else if (|flip_s) begin
            result_s = SEC_DATA;
        end else begin
            result_s = DED;
        end
    end

    // Flags from the decode result.
    always_comb begin
        sec = 1'b0;
        ded = 1'b0;
        case (result_s)
            SEC_DATA, SEC_CHECK: sec = 1'b1;
            DED:                 ded = 1'b1;
            NONE:                sec = 1'b0;
            default: begin
                sec = 1'b0;
                ded = 1'b0;
            end
        endcase
    end

    // flip_s is non-zero only for a data-bit match, so no extra gating is needed.
    assign fixed_data = cor_data ^ flip_s;
    assign fixed_ecc  = gen_check(fixed_data);

endmodule

// File: rtl/edc_secded_pipe.sv
// Pipelined multi-lane SECDED encode/check engine with valid/ready and error counters.
module edc_secded_pipe
    import edc_pkg::*;
#(
    parameter int LANES       = 1,
    parameter int PIPE_STAGES = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic                         i_write,
    input  logic [DATA_W*LANES-1:0]      i_data,
    input  logic [CHECK_W*LANES-1:0]     i_ecc,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [DATA_W*LANES-1:0]      o_data,
    output logic [CHECK_W*LANES-1:0]     o_ecc,
    output logic [CHECK_W*LANES-1:0]     o_syndrome,
    output logic [LANES-1:0]             o_sec,
    output logic [LANES-1:0]             o_ded,
    input  logic                         i_cnt_clr,
    output logic [CNT_WIDTH-1:0]         o_sec_cnt,
    output logic [CNT_WIDTH-1:0]         o_ded_cnt
);

    localparam int DW    = DATA_W * LANES;
    localparam int CW    = CHECK_W * LANES;
    localparam int SUM_W = CNT_WIDTH + 4;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic                 advance_s;
    logic                 xfer_s;
    logic                 stage_valid_s;
    logic [CW-1:0]        gen_syn_s;
    logic [DW-1:0]        cor_data_s;
    logic [CW-1:0]        cor_syn_s;
    logic [DW-1:0]        fix_data_s;
    logic [CW-1:0]        fix_ecc_s;
    logic [LANES-1:0]     fix_sec_s;
    logic [LANES-1:0]     fix_ded_s;
    logic [SUM_W-1:0]     sec_sum_s;
    logic [SUM_W-1:0]     ded_sum_s;
    logic [CNT_WIDTH-1:0] sec_next_s;
    logic [CNT_WIDTH-1:0] ded_next_s;
    logic [CNT_WIDTH-1:0] sec_cnt_r;
    logic [CNT_WIDTH-1:0] ded_cnt_r;

    // Whole pipeline moves together; a stalled output freezes every stage.
    assign advance_s = ~o_valid | i_ready;
    assign o_ready   = advance_s;
    assign xfer_s    = o_valid & i_ready;

    genvar gl;
    generate
        for (gl = 0; gl < LANES; gl++) begin : g_lane
            edc_lane_decode u_lane (
                .syn_data     (i_data[gl*DATA_W +: DATA_W]),
                .syn_ecc      (i_ecc[gl*CHECK_W +: CHECK_W]),
                .syn_write    (i_write),
                .syndrome     (gen_syn_s[gl*CHECK_W +: CHECK_W]),
                .cor_data     (cor_data_s[gl*DATA_W +: DATA_W]),
                .cor_syndrome (cor_syn_s[gl*CHECK_W +: CHECK_W]),
                .fixed_data   (fix_data_s[gl*DATA_W +: DATA_W]),
                .fixed_ecc    (fix_ecc_s[gl*CHECK_W +: CHECK_W]),
                .sec          (fix_sec_s[gl]),
                .ded          (fix_ded_s[gl])
            );
        end

        if (PIPE_STAGES == 2) begin : g_two_stage
            logic          s1_valid_r;
            logic [DW-1:0] s1_data_r;
            logic [CW-1:0] s1_syn_r;

            // Stage 1 register: raw data plus syndrome, decoded in the output stage.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    s1_valid_r <= 1'b0;
                    s1_data_r  <= '0;
                    s1_syn_r   <= '0;
                end else if (advance_s) begin
                    s1_valid_r <= i_valid;
                    s1_data_r  <= i_data;
                    s1_syn_r   <= gen_syn_s;
                end
            end

            assign stage_valid_s = s1_valid_r;
            assign cor_data_s    = s1_data_r;
            assign cor_syn_s     = s1_syn_r;
        end else begin : g_one_stage
            assign stage_valid_s = i_valid;
            assign cor_data_s    = i_data;
            assign cor_syn_s     = gen_syn_s;
        end
    endgenerate

    // Output stage register; bubbles leave the previous payload in place.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_ecc      <= '0;
            o_syndrome <= '0;
            o_sec      <= '0;
            o_ded      <= '0;
        end else if (advance_s) begin
            o_valid <= stage_valid_s;
            if (stage_valid_s) begin
                o_data     <= fix_data_s;
                o_ecc      <= fix_ecc_s;
                o_syndrome <= cor_syn_s;
                o_sec      <= fix_sec_s;
                o_ded      <= fix_ded_s;
            end
        end
    end

    // Saturating next values: add the flag popcounts in a wider sum, then clamp.
    always_comb begin
        sec_sum_s = {4'd0, sec_cnt_r};
        ded_sum_s = {4'd0, ded_cnt_r};
        for (int l = 0; l < LANES; l++) begin
            sec_sum_s = sec_sum_s + {{(SUM_W-1){1'b0}}, o_sec[l]};
            ded_sum_s = ded_sum_s + {{(SUM_W-1){1'b0}}, o_ded[l]};
        end
        if (sec_sum_s > {4'd0, CNT_MAX}) begin
            sec_next_s = CNT_MAX;
        end else begin
            sec_next_s = sec_sum_s[CNT_WIDTH-1:0];
        end
        if (ded_sum_s > {4'd0, CNT_MAX}) begin
            ded_next_s = CNT_MAX;
        end else begin
            ded_next_s = ded_sum_s[CNT_WIDTH-1:0];
        end
    end

    // Error counters; clear wins over a same-cycle transfer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sec_cnt_r <= '0;
            ded_cnt_r <= '0;
        end else if (i_cnt_clr) begin
            sec_cnt_r <= '0;
            ded_cnt_r <= '0;
        end else if (xfer_s) begin
            sec_cnt_r <= sec_next_s;
            ded_cnt_r <= ded_next_s;
        end
    end

    assign o_sec_cnt = sec_cnt_r;
    assign o_ded_cnt = ded_cnt_r;

endmodule

// File: tb/tb_edc_secded_pipe.sv
// Scoreboard bench for edc_secded_pipe: driver pushes model results, monitor pops and compares.
module tb_edc_secded_pipe;

    localparam int LANES       = 2;
    localparam int PIPE_STAGES = 2;
    localparam int CNT_WIDTH   = 2;
    localparam int CNT_MAX     = (1 << CNT_WIDTH) - 1;
    localparam int DEPTH       = 1024;

    // H rows indexed by check bit number (entry 0 is row 0).
    localparam logic [31:0] HR [8] = '{32'h03035555, 32'h0C0CAAAA, 32'h303000FF, 32'hC0C0FF00,
                                       32'h00FF0303, 32'hFF000C0C, 32'h55553030, 32'hAAAAC0C0};

    typedef struct packed {
        logic [63:0] data;
        logic [15:0] ecc;
        logic [15:0] syn;
        logic [1:0]  sec;
        logic [1:0]  ded;
    } beat_t;

    logic                 clk;
    logic                 rst;
    logic                 i_valid;
    logic                 o_ready;
    logic                 i_write;
    logic [63:0]          i_data;
    logic [15:0]          i_ecc;
    logic                 o_valid;
    logic                 i_ready;
    logic [63:0]          o_data;
    logic [15:0]          o_ecc;
    logic [15:0]          o_syndrome;
    logic [1:0]           o_sec;
    logic [1:0]           o_ded;
    logic                 i_cnt_clr;
    logic [CNT_WIDTH-1:0] o_sec_cnt;
    logic [CNT_WIDTH-1:0] o_ded_cnt;

    beat_t exp_mem [DEPTH];
    int wr_idx   = 0;
    int rd_idx   = 0;
    int d_checks = 0;
    int d_pass   = 0;
    int m_checks = 0;
    int m_pass   = 0;

    edc_secded_pipe #(
        .LANES       (LANES),
        .PIPE_STAGES (PIPE_STAGES),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_write    (i_write),
        .i_data     (i_data),
        .i_ecc      (i_ecc),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_ecc      (o_ecc),
        .o_syndrome (o_syndrome),
        .o_sec      (o_sec),
        .o_ded      (o_ded),
        .i_cnt_clr  (i_cnt_clr),
        .o_sec_cnt  (o_sec_cnt),
        .o_ded_cnt  (o_ded_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] col_of(input int j);
        logic [7:0] c;
        for (int r = 0; r < 8; r++) c[r] = HR[r][j];
        return c;
    endfunction

    // Check byte as the XOR of the columns of all set data bits.
    function automatic logic [7:0] ref_check(input logic [31:0] d);
        logic [7:0] c;
        c = 8'd0;
        for (int j = 0; j < 32; j++) if (d[j]) c = c ^ col_of(j);
        return c;
    endfunction

    function automatic beat_t ref_beat(input logic w, input logic [63:0] d, input logic [15:0] e);
        beat_t      b;
        logic [31:0] ld;
        logic [7:0]  s;
        int          hit;
        b = '0;
        for (int l = 0; l < LANES; l++) begin
            ld = d[l*32 +: 32];
            if (w) begin
                b.data[l*32 +: 32] = ld;
                b.ecc[l*8 +: 8]    = ref_check(ld);
            end else begin
                s   = ref_check(ld) ^ e[l*8 +: 8];
                hit = -1;
                for (int j = 0; j < 32; j++) if (s != 8'd0 && col_of(j) == s) hit = j;
                if (hit >= 0) begin
                    ld[hit]  = ~ld[hit];
                    b.sec[l] = 1'b1;
                end else if ($countones(s) == 1) begin
                    b.sec[l] = 1'b1;
                end else if (s != 8'd0) begin
                    b.ded[l] = 1'b1;
                end
                b.syn[l*8 +: 8]    = s;
                b.data[l*32 +: 32] = ld;
                b.ecc[l*8 +: 8]    = ref_check(ld);
            end
        end
        return b;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    task automatic mcheck(input string name, input logic [127:0] got, input logic [127:0] req);
        m_checks++;
        if (got === req) m_pass++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, req, $time);
    endtask

    initial begin
        beat_t        exp_b;
        logic [99:0]  snap;
        logic         held;
        int           m_sec;
        int           m_ded;
        int           inc_s;
        int           inc_d;
        held  = 1'b0;
        snap  = '0;
        m_sec = 0;
        m_ded = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                rd_idx = wr_idx;
                m_sec  = 0;
                m_ded  = 0;
                held   = 1'b0;
            end else begin
                mcheck("sec_cnt", o_sec_cnt, m_sec);
                mcheck("ded_cnt", o_ded_cnt, m_ded);
                if (held) mcheck("stall_stable", {o_valid, o_data, o_ecc, o_syndrome, o_sec, o_ded},
                                 {1'b1, snap});
                held  = 1'b0;
                inc_s = 0;
                inc_d = 0;
                if (o_valid && !i_ready) begin
                    mcheck("o_ready_stalled", o_ready, 1'b0);
                    held = 1'b1;
                    snap = {o_data, o_ecc, o_syndrome, o_sec, o_ded};
                end
                if (o_valid && i_ready) begin
                    if (rd_idx == wr_idx) begin
                        m_checks++;
                        $display("FAIL unexpected_beat: got output beat, required none pending");
                    end else begin
                        exp_b = exp_mem[rd_idx % DEPTH];
                        rd_idx++;
                        mcheck("o_data", o_data, exp_b.data);
                        mcheck("o_ecc", o_ecc, exp_b.ecc);
                        mcheck("o_syndrome", o_syndrome, exp_b.syn);
                        mcheck("o_sec", o_sec, exp_b.sec);
                        mcheck("o_ded", o_ded, exp_b.ded);
                        inc_s = $countones(exp_b.sec);
                        inc_d = $countones(exp_b.ded);
                    end
                end
                if (i_cnt_clr) begin
                    m_sec = 0;
                    m_ded = 0;
                end else begin
                    m_sec = (m_sec + inc_s > CNT_MAX) ? CNT_MAX : m_sec + inc_s;
                    m_ded = (m_ded + inc_d > CNT_MAX) ? CNT_MAX : m_ded + inc_d;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
        d_checks++;
        if (got === req) d_pass++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, req, $time);
    endtask

    // One cycle of stimulus; an accepted beat gets its model result queued.
    task automatic step(input logic v, input logic w, input logic [63:0] d, input logic [15:0] e,
                        input logic rdy, input logic clr, output logic acc);
        @(negedge clk);
        i_valid   = v;
        i_write   = w;
        i_data    = d;
        i_ecc     = e;
        i_ready   = rdy;
        i_cnt_clr = clr;
        #1;
        acc = v && o_ready;
        if (acc) begin
            exp_mem[wr_idx % DEPTH] = ref_beat(w, d, e);
            wr_idx++;
        end
    endtask

    task automatic idle(input logic rdy);
        logic acc;
        step(1'b0, 1'b0, 64'd0, 16'd0, rdy, 1'b0, acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            idle(1'b1);
            n++;
        end while ((rd_idx != wr_idx || o_valid) && n < 50);
        chk("drain_pending", wr_idx - rd_idx, 0);
    endtask

    // Single beat on an idle pipe: checks latency and literal expected outputs.
    task automatic send_check(input string name, input logic w, input logic [63:0] d,
                              input logic [15:0] e, input logic [63:0] xd, input logic [15:0] xe,
                              input logic [15:0] xs, input logic [1:0] xsec, input logic [1:0] xded);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            step(1'b1, w, d, e, 1'b1, 1'b0, acc);
            n++;
        end
        chk({name, "_accept"}, acc, 1'b1);
        n = 0;
        do begin
            idle(1'b0);
            n++;
        end while (!o_valid && n < 10);
        chk({name, "_latency"}, n, PIPE_STAGES);
        chk({name, "_data"}, o_data, xd);
        chk({name, "_ecc"}, o_ecc, xe);
        chk({name, "_syn"}, o_syndrome, xs);
        chk({name, "_sec"}, o_sec, xsec);
        chk({name, "_ded"}, o_ded, xded);
        idle(1'b1);
    endtask

    task automatic rand_beat(input logic force_read, output logic w, output logic [63:0] d,
                             output logic [15:0] e);
        logic [39:0] cw;
        int          p1;
        int          p2;
        w = force_read ? 1'b0 : ($urandom_range(0, 2) == 0);
        for (int l = 0; l < LANES; l++) begin
            cw[31:0]  = $urandom;
            cw[39:32] = ref_check(cw[31:0]);
            case ($urandom_range(0, 4))
                1: cw[$urandom_range(0, 31)] ^= 1'b1;
                2: cw[$urandom_range(32, 39)] ^= 1'b1;
                3: begin
                    p1 = $urandom_range(0, 39);
                    p2 = (p1 + 1 + $urandom_range(0, 38)) % 40;
                    cw[p1] ^= 1'b1;
                    cw[p2] ^= 1'b1;
                end
                4: cw[39:32] = 8'($urandom);
                default: cw[39:32] = cw[39:32];
            endcase
            d[l*32 +: 32] = cw[31:0];
            e[l*8 +: 8]   = cw[39:32];
        end
    endtask

    initial begin
        logic        acc;
        logic        w;
        logic [63:0] d;
        logic [15:0] e;
        int          n;
        int          acc_n;

        rst       = 1'b1;
        i_valid   = 1'b0;
        i_write   = 1'b0;
        i_data    = 64'd0;
        i_ecc     = 16'd0;
        i_ready   = 1'b0;
        i_cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_o_ready", o_ready, 1'b1);
        chk("rst_outputs", {o_data, o_ecc, o_syndrome, o_sec, o_ded}, 100'd0);
        chk("rst_counters", {o_sec_cnt, o_ded_cnt}, 4'd0);

        // Directed encode / decode vectors.
        send_check("wr_single_bits", 1'b1, {32'h80000000, 32'h00000001}, 16'hFFFF,
                   {32'h80000000, 32'h00000001}, 16'hA815, 16'h0000, 2'b00, 2'b00);
        send_check("wr_all_ones", 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFF}, 16'h0000,
                   {32'hFFFFFFFF, 32'hFFFFFFFF}, 16'h0000, 16'h0000, 2'b00, 2'b00);
        send_check("rd_sec_data_check", 1'b0, {32'h00000000, 32'h00000001}, 16'h0400,
                   64'd0, 16'h0000, 16'h0415, 2'b11, 2'b00);
        send_check("rd_ded", 1'b0, {32'h00000000, 32'h00000003}, 16'h0000,
                   {32'h00000000, 32'h00000003}, 16'h0003, 16'h0003, 2'b00, 2'b01);
        drain();

        // Backpressure: four beats streamed with a three-cycle downstream stall.
        acc_n = 0;
        n     = 0;
        while (acc_n < 4 && n < 30) begin
            rand_beat(1'b0, w, d, e);
            step(1'b1, w, d, e, !(n >= 2 && n < 5), 1'b0, acc);
            if (acc) acc_n++;
            n++;
        end
        chk("bp_accepted", acc_n, 4);
        drain();

        // Counter saturation: two corrected lanes per beat for three beats.
        step(1'b0, 1'b0, 64'd0, 16'd0, 1'b1, 1'b1, acc);
        for (int b = 0; b < 3; b++) begin
            d = {32'($urandom), 32'($urandom)};
            e = {ref_check(d[63:32]), ref_check(d[31:0])};
            d[$urandom_range(0, 31)]  ^= 1'b1;
            d[$urandom_range(32, 63)] ^= 1'b1;
            step(1'b1, 1'b0, d, e, 1'b1, 1'b0, acc);
        end
        drain();
        chk("sec_cnt_saturated", o_sec_cnt, 2'd3);

        // Clear coinciding with a single-error transfer.
        d = {32'h0, 32'h00000001};
        step(1'b1, 1'b0, d, 16'h0000, 1'b0, 1'b0, acc);
        n = 0;
        do begin
            idle(1'b0);
            n++;
        end while (!o_valid && n < 10);
        step(1'b0, 1'b0, 64'd0, 16'd0, 1'b1, 1'b1, acc);
        idle(1'b1);
        chk("sec_cnt_clr_priority", o_sec_cnt, 2'd0);

        // Randomized traffic with random backpressure and occasional clears.
        for (int c = 0; c < 400; c++) begin
            rand_beat(1'b0, w, d, e);
            step($urandom_range(0, 9) < 8, w, d, e, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 29) == 0, acc);
        end
        drain();

        // Build up counts, then reset with two beats in flight.
        for (int b = 0; b < 2; b++) begin
            rand_beat(1'b1, w, d, e);
            d[0] ^= 1'b1;
            step(1'b1, 1'b0, d, {ref_check(d[63:32]), ref_check(d[31:0] ^ 32'd1)}, 1'b1, 1'b0, acc);
        end
        for (int b = 0; b < 2; b++) begin
            rand_beat(1'b1, w, d, e);
            step(1'b1, w, d, e, 1'b0, 1'b0, acc);
        end
        @(posedge clk);
        #3;
        i_valid = 1'b0;
        rst     = 1'b1;
        #1;
        chk("midrst_o_valid", o_valid, 1'b0);
        chk("midrst_counters", {o_sec_cnt, o_ded_cnt}, 4'd0);
        @(negedge clk);
        #3 rst = 1'b0;
        send_check("post_rst", 1'b0, {32'h00000000, 32'h00000001}, 16'h0000,
                   64'd0, 16'h0000, 16'h0015, 2'b01, 2'b00);
        drain();

        $display("%0d/%0d checks passed", d_pass + m_pass, d_checks + m_checks);
        $finish;
    end

endmodule
